// File: rtl/captura_operandos.sv
// Operand capture for a switch/button calculator front end: synchronizes and
// debounces the load button, then steps A -> B -> ready -> clear on each press.
module captura_operandos #(
  parameter int REBOTE_CICLOS = 100000
) (
  input  logic       Reloj,
  input  logic       Reset,
  input  logic [3:0] Interruptores,
  input  logic       Boton,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Listo,
  output logic [1:0] Fase
);

  localparam int CW = (REBOTE_CICLOS > 1) ? $clog2(REBOTE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REBOTE_CICLOS - 1);

  typedef enum logic [1:0] {
    CAPTURA_A = 2'b00,
    CAPTURA_B = 2'b01,
    LISTO     = 2'b10,
    ILEGAL    = 2'b11
  } estado_t;

  logic [1:0]    sinc_q;
  logic          sinc;
  logic          estable_q, estable_d, estable_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso;

  estado_t       state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic          listo_q, listo_d;

  assign sinc = sinc_q[1];

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      sinc_q         <= 2'b00;
      estable_q      <= 1'b0;
      estable_prev_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      sinc_q         <= {sinc_q[0], Boton};
      estable_q      <= estable_d;
      estable_prev_q <= estable_q;
      cnt_q          <= cnt_d;
    end
  end

  // Level is only accepted after REBOTE_CICLOS consecutive disagreeing cycles;
  // any agreement restarts the count.
  always_comb begin
    estable_d = estable_q;
    cnt_d     = '0;
    if (sinc != estable_q) begin
      if (cnt_q == CNT_MAX) estable_d = sinc;
      else                  cnt_d     = cnt_q + 1'b1;
    end
  end

  assign pulso = estable_q & ~estable_prev_q;

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      state_q <= CAPTURA_A;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      listo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      listo_q <= listo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    listo_d = listo_q;
    case (state_q)
      CAPTURA_A: if (pulso) begin
        a_d     = Interruptores;
        state_d = CAPTURA_B;
      end
      CAPTURA_B: if (pulso) begin
        b_d     = Interruptores;
        listo_d = 1'b1;
        state_d = LISTO;
      end
      LISTO: if (pulso) begin
        a_d     = 4'h0;
        b_d     = 4'h0;
        listo_d = 1'b0;
        state_d = CAPTURA_A;
      end
      default: begin
        a_d     = 4'h0;
        b_d     = 4'h0;
        listo_d = 1'b0;
        state_d = CAPTURA_A;
      end
    endcase
  end

  assign A     = a_q;
  assign B     = b_q;
  assign Listo = listo_q;
  assign Fase  = state_q;

endmodule
